sky130_sram_port0_arb: RTL and testbench

SKY130_SRAM_PORT0_ARB -- requirements
Module: sky130_sram_port0_arb

---
 rtl/sky130_sram_arb_pkg.sv | 22 ++
 rtl/sky130_sram_rr_arb2.sv | 47 ++++
 rtl/sky130_sram_port0_arb.sv | 148 ++++++++++++++
 tb/tb_sky130_sram_port0_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sky130_sram_arb_pkg.sv
// State encoding and default widths for the sky130 SRAM port-0 arbiter.
// SKY130_SRAM_ARB_INIT_EN adds the INIT (zero-fill) state; without it the FSM is IDLE/SERVE only.
package sky130_sram_arb_pkg;

   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

`ifdef SKY130_SRAM_ARB_INIT_EN
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INIT  = 2'd1,
      ST_SERVE = 2'd2
   } state_e;
`else
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_e;
`endif

endpackage

// File: rtl/sky130_sram_rr_arb2.sv
// Two-way round-robin grant, combinational from the requests; only the last-grant bit is registered.
// On contention the master not granted last wins; a lone requester wins every cycle.
module sky130_sram_rr_arb2 (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   // 1 = m1 was granted most recently, so m0 wins the next tie
   logic last_q, last_d;

   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (en_i) begin
         if (req0_i && req1_i) begin
            gnt0_o = last_q;
            gnt1_o = !last_q;
         end else begin
            gnt0_o = req0_i;
            gnt1_o = req1_i;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt0_o) begin
         last_d = 1'b0;
      end else if (gnt1_o) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/sky130_sram_port0_arb.sv
// Shares port 0 of a sky130 OpenRAM macro between two masters; grant and macro drive are combinational, read data returns one cycle after accept.
// With SKY130_SRAM_ARB_INIT_EN defined the macro is zero-filled after reset before any request is accepted.
module sky130_sram_port0_arb
   import sky130_sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
   input  logic                  clk0,
   input  logic                  rst0_n,

   input  logic                  m0_req_valid,
   output logic                  m0_req_ready,
   input  logic                  m0_req_we,
   input  logic [NUM_WMASKS-1:0] m0_req_wmask,
   input  logic [ADDR_WIDTH-1:0] m0_req_addr,
   input  logic [DATA_WIDTH-1:0] m0_req_wdata,
   output logic                  m0_rsp_valid,
   output logic [DATA_WIDTH-1:0] m0_rsp_rdata,

   input  logic                  m1_req_valid,
   output logic                  m1_req_ready,
   input  logic                  m1_req_we,
   input  logic [NUM_WMASKS-1:0] m1_req_wmask,
   input  logic [ADDR_WIDTH-1:0] m1_req_addr,
   input  logic [DATA_WIDTH-1:0] m1_req_wdata,
   output logic                  m1_rsp_valid,
   output logic [DATA_WIDTH-1:0] m1_rsp_rdata,

   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,

   output logic                  init_done
);

   state_e state_q, state_d;
   logic   serve;
   logic   gnt0, gnt1;
   logic   rsp0_q, rsp0_d;
   logic   rsp1_q, rsp1_d;

`ifdef SKY130_SRAM_ARB_INIT_EN
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`endif

   assign serve     = (state_q == ST_SERVE);
   assign init_done = serve;

   sky130_sram_rr_arb2 u_arb (
      .clk_i   (clk0),
      .rst_n_i (rst0_n),
      .en_i    (serve),
      .req0_i  (m0_req_valid),
      .req1_i  (m1_req_valid),
      .gnt0_o  (gnt0),
      .gnt1_o  (gnt1)
   );

   assign m0_req_ready = gnt0;
   assign m1_req_ready = gnt1;

   always_comb begin
      state_d = state_q;
`ifdef SKY130_SRAM_ARB_INIT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
`ifdef SKY130_SRAM_ARB_INIT_EN
         ST_IDLE: state_d = ST_INIT;
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = ST_SERVE;
            end
         end
`else
         ST_IDLE: state_d = ST_SERVE;
`endif
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      if (gnt0) begin
         sram_csb0   = 1'b0;
         sram_web0   = !m0_req_we;
         sram_wmask0 = m0_req_wmask;
         sram_addr0  = m0_req_addr;
         sram_din0   = m0_req_wdata;
      end else if (gnt1) begin
         sram_csb0   = 1'b0;
         sram_web0   = !m1_req_we;
         sram_wmask0 = m1_req_wmask;
         sram_addr0  = m1_req_addr;
         sram_din0   = m1_req_wdata;
      end
`ifdef SKY130_SRAM_ARB_INIT_EN
      if (state_q == ST_INIT) begin
         sram_csb0   = 1'b0;
         sram_web0   = 1'b0;
         sram_wmask0 = '1;
         sram_addr0  = cnt_q;
      end
`endif
   end

   assign rsp0_d = gnt0 && !m0_req_we;
   assign rsp1_d = gnt1 && !m1_req_we;

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state_q <= ST_IDLE;
         rsp0_q  <= 1'b0;
         rsp1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rsp0_q  <= rsp0_d;
         rsp1_q  <= rsp1_d;
      end
   end

`ifdef SKY130_SRAM_ARB_INIT_EN
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // Read data passes straight from the macro: clk0 low phase must exceed the macro output delay.
   assign m0_rsp_valid = rsp0_q;
   assign m1_rsp_valid = rsp1_q;
   assign m0_rsp_rdata = rsp0_q ? sram_dout0 : '0;
   assign m1_rsp_rdata = rsp1_q ? sram_dout0 : '0;

endmodule

// File: tb/tb_sky130_sram_port0_arb.sv
// Bench for sky130_sram_port0_arb: behavioural macro plus a transaction-level reference model.
// Follows SKY130_SRAM_ARB_INIT_EN the same way as the RTL.
module tb_sky130_sram_port0_arb;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int MW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk0 = 1'b0;
   logic          rst0_n = 1'b0;
   logic          m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid;
   logic [MW-1:0] m0_req_wmask;
   logic [AW-1:0] m0_req_addr;
   logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
   logic          m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid;
   logic [MW-1:0] m1_req_wmask;
   logic [AW-1:0] m1_req_addr;
   logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
   logic          sram_csb0, sram_web0, init_done;
   logic [MW-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0, sram_dout0;

   always #5 clk0 = ~clk0;

   sky130_sram_port0_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(MW)) dut (
      .clk0(clk0), .rst0_n(rst0_n),
      .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
      .m0_req_wmask(m0_req_wmask), .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
      .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
      .m1_req_wmask(m1_req_wmask), .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .init_done(init_done)
   );

   // Behavioural single-port macro: inputs latched on the rising edge, read data updated there too.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk0) begin
      if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < MW; b++)
               if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
         end else begin
            sram_dout0 <= mem[sram_addr0];
         end
      end
   end

   // Reference model state: expected memory image, last winner, pending read responses.
   logic [DW-1:0] ref_mem [DEPTH];
   int            mdl_last;
   bit            pend0, pend1;
   logic [DW-1:0] pend_dat;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] bus_now();
      return 64'({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0});
   endfunction

   function automatic logic [63:0] bus_idle();
      return 64'(3) << (MW + AW + DW);
   endfunction

   task automatic set_req(input int m, input bit v, input bit we, input logic [MW-1:0] mk,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (m == 0) begin
         m0_req_valid = v; m0_req_we = we; m0_req_wmask = mk; m0_req_addr = a; m0_req_wdata = d;
      end else begin
         m1_req_valid = v; m1_req_we = we; m1_req_wmask = mk; m1_req_addr = a; m1_req_wdata = d;
      end
   endtask

   task automatic rand_req(input int m);
      set_req(m, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), MW'($urandom),
              AW'($urandom_range(0, 7)), $urandom);
   endtask

   // One clock cycle: check outputs at the falling edge, then advance the model at the rising edge.
   task automatic cycle_chk(input bit serve);
      int            owner;
      bit            we;
      logic [MW-1:0] mk;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [63:0]   eb;
      @(negedge clk0);
      owner = -1;
      if (serve) begin
         if (m0_req_valid && m1_req_valid) owner = (mdl_last == 1) ? 0 : 1;
         else if (m0_req_valid)            owner = 0;
         else if (m1_req_valid)            owner = 1;
      end
      we = 1'b0; mk = '0; a = '0; d = '0;
      if (owner == 0) begin
         we = m0_req_we; mk = m0_req_wmask; a = m0_req_addr; d = m0_req_wdata;
      end else if (owner == 1) begin
         we = m1_req_we; mk = m1_req_wmask; a = m1_req_addr; d = m1_req_wdata;
      end
      eb = (owner < 0) ? bus_idle() : 64'({1'b0, !we, mk, a, d});
      chk("init_done", 64'(init_done), 64'(serve));
      chk("rdy0", 64'(m0_req_ready), 64'(owner == 0));
      chk("rdy1", 64'(m1_req_ready), 64'(owner == 1));
      chk("rsp0_vld", 64'(m0_rsp_valid), 64'(pend0));
      chk("rsp1_vld", 64'(m1_rsp_valid), 64'(pend1));
      chk("rsp0_dat", 64'(m0_rsp_rdata), pend0 ? 64'(pend_dat) : 64'(0));
      chk("rsp1_dat", 64'(m1_rsp_rdata), pend1 ? 64'(pend_dat) : 64'(0));
      chk("sram_bus", bus_now(), eb);
      @(posedge clk0);
      pend0 = 1'b0;
      pend1 = 1'b0;
      if (owner >= 0) begin
         mdl_last = owner;
         if (we) begin
            for (int b = 0; b < MW; b++)
               if (mk[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
         end else begin
            pend_dat = ref_mem[a];
            if (owner == 0) pend0 = 1'b1;
            else            pend1 = 1'b1;
         end
      end
      #1;
   endtask

   // Asserts reset, checks outputs fall without a clock edge, releases just after the next rising edge.
   task automatic do_reset();
      rst0_n = 1'b0;
      #1;
      chk("rst_init_done", 64'(init_done), 64'(0));
      chk("rst_rdy0", 64'(m0_req_ready), 64'(0));
      chk("rst_rsp0_vld", 64'(m0_rsp_valid), 64'(0));
      chk("rst_rsp0_dat", 64'(m0_rsp_rdata), 64'(0));
      chk("rst_rsp1_vld", 64'(m1_rsp_valid), 64'(0));
      chk("rst_bus", bus_now(), bus_idle());
      mdl_last = 1;
      pend0 = 1'b0;
      pend1 = 1'b0;
      @(posedge clk0);
      #1;
      rst0_n = 1'b1;
   endtask

`ifdef SKY130_SRAM_ARB_INIT_EN
   // Zero-fill walk; stops at the falling edge of cycle stop_at, or runs to completion if stop_at >= DEPTH.
   task automatic run_init(input int stop_at);
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk0);
         chk("init_bus", bus_now(), 64'({1'b0, 1'b0, {MW{1'b1}}, AW'(i), DW'(0)}));
         chk("init_rdy0", 64'(m0_req_ready), 64'(0));
         chk("init_done_lo", 64'(init_done), 64'(0));
         if (i == stop_at) return;
         @(posedge clk0);
         #1;
      end
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask
`endif

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef SKY130_SRAM_ARB_INIT_EN
         mem[i] <= 32'hA5A5_0000 | DW'(i);
`else
         mem[i] <= '0;
`endif
         ref_mem[i] = '0;
      end
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      mdl_last = 1;
      pend0 = 1'b0;
      pend1 = 1'b0;
      repeat (2) @(posedge clk0);
      #1;
      do_reset();

      // First request is already waiting during IDLE.
      set_req(0, 1'b1, 1'b0, '0, AW'(10'h3FF), '0);
      cycle_chk(1'b0);
`ifdef SKY130_SRAM_ARB_INIT_EN
      run_init(DEPTH);
`endif
      cycle_chk(1'b1);
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      cycle_chk(1'b1);

`ifdef SKY130_SRAM_ARB_INIT_EN
      // Reset in the middle of the fill restarts it from address 0.
      set_req(0, 1'b1, 1'b0, '0, '0, '0);
      do_reset();
      cycle_chk(1'b0);
      run_init(10'h200);
      #1;
      do_reset();
      cycle_chk(1'b0);
      run_init(DEPTH);
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      cycle_chk(1'b1);
`endif

      // Byte-masked write then read-back on the following cycle.
      set_req(0, 1'b1, 1'b1, 4'b0101, AW'(10'h005), 32'hDEADBEEF);
      cycle_chk(1'b1);
      set_req(0, 1'b1, 1'b0, '0, AW'(10'h005), '0);
      cycle_chk(1'b1);
      #2;
      chk("masked_rd_005", 64'(m0_rsp_rdata), 64'(32'h00AD00EF));
      set_req(0, 1'b0, 1'b0, '0, '0, '0);

      // Lone m1 requester, five back-to-back grants.
      for (int i = 0; i < 5; i++) begin
         set_req(1, 1'b1, 1'($urandom_range(0, 1)), MW'($urandom), AW'(i), $urandom);
         cycle_chk(1'b1);
      end
      set_req(1, 1'b0, 1'b0, '0, '0, '0);

      // Both masters reading continuously must alternate.
      for (int i = 0; i < 8; i++) begin
         set_req(0, 1'b1, 1'b0, '0, AW'(i), '0);
         set_req(1, 1'b1, 1'b0, '0, AW'(i + 1), '0);
         cycle_chk(1'b1);
      end

      // Random traffic over a small address window to hit write-then-read collisions.
      for (int i = 0; i < 300; i++) begin
         rand_req(0);
         rand_req(1);
         cycle_chk(1'b1);
      end

      // Reset with a read response in flight drops it.
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      set_req(0, 1'b1, 1'b0, '0, AW'(10'h005), '0);
      cycle_chk(1'b1);
      chk("rsp_before_rst", 64'(m0_rsp_valid), 64'(1));
      do_reset();
      set_req(0, 1'b1, 1'b0, '0, AW'(10'h005), '0);
      cycle_chk(1'b0);
`ifdef SKY130_SRAM_ARB_INIT_EN
      run_init(DEPTH);
`endif
      for (int i = 0; i < 4; i++) begin
         rand_req(0);
         rand_req(1);
         cycle_chk(1'b1);
      end
      set_req(0, 1'b0, 1'b0, '0, '0, '0);
      set_req(1, 1'b0, 1'b0, '0, '0, '0);
      cycle_chk(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
